// File: rtl/config_pkg.sv
// Shared configuration for the SPI receiver: default frame geometry and
// the receive FSM state encoding.
package config_pkg;

    localparam int P_DATA_WIDTH = 8;
    localparam int P_BEATS      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } spi_rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Small circular word buffer between the SPI frame assembler and the
// consumer. A push into a full buffer is dropped unless a pop happens in
// the same cycle, in which case both are performed.
module spi_rx_fifo #(
    parameter int P_WIDTH = 16,
    parameter int P_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [P_WIDTH-1:0] wr_data,
    input  logic               pop,
    output logic [P_WIDTH-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int CNT_W = $clog2(P_DEPTH + 1);

    logic [P_WIDTH-1:0] mem_r [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    // Pointers wrap at P_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(P_DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign full      = (count_r == CNT_W'(P_DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rd_data   = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spi_receiver.sv
// SPI slave receiver: synchronises SCK/CS/MOSI into clk_100, assembles
// P_BEATS beats of P_DATA_WIDTH lanes into a word (first beat in the MSBs)
// and hands completed words to a ready/valid output through a small FIFO.
module spi_receiver #(
    parameter int P_DATA_WIDTH = config_pkg::P_DATA_WIDTH,
    parameter int P_BEATS      = config_pkg::P_BEATS,
    parameter int P_FIFO_DEPTH = 2
) (
    input  logic                            clk_100,
    input  logic                            a_rst,
    input  logic                            SCK,
    input  logic                            CS,
    input  logic [P_DATA_WIDTH-1:0]         MOSI,
    output logic [P_BEATS*P_DATA_WIDTH-1:0] data,
    output logic                            valid,
    input  logic                            ready,
    output logic                            busy,
    output logic                            frame_err,
    output logic                            overflow
);

    import config_pkg::*;

    localparam int W      = P_BEATS * P_DATA_WIDTH;
    localparam int BEAT_W = (P_BEATS > 1) ? $clog2(P_BEATS) : 1;

    logic                    cs_s1_r, cs_s2_r;
    logic                    sck_s1_r, sck_s2_r, sck_d_r;
    logic [P_DATA_WIDTH-1:0] mosi_s1_r, mosi_s2_r;
    logic                    sck_rise_s;

    spi_rx_state_t           state_r, state_nx;
    logic [BEAT_W-1:0]       beat_r, beat_nx;
    logic [W-1:0]            shift_r, shift_nx;
    logic                    push_r, push_nx;
    logic                    frame_err_r, frame_err_nx;
    logic                    busy_r;
    logic                    overflow_r;

    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic                    pop_s;

    // Two-flop synchronisers; all three inputs share the same depth so a
    // detected SCK rise sees the MOSI and CS values from the same instant.
    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) begin
            cs_s1_r   <= 1'b1;
            cs_s2_r   <= 1'b1;
            sck_s1_r  <= 1'b0;
            sck_s2_r  <= 1'b0;
            sck_d_r   <= 1'b0;
            mosi_s1_r <= '0;
            mosi_s2_r <= '0;
        end else begin
            cs_s1_r   <= CS;
            cs_s2_r   <= cs_s1_r;
            sck_s1_r  <= SCK;
            sck_s2_r  <= sck_s1_r;
            sck_d_r   <= sck_s2_r;
            mosi_s1_r <= MOSI;
            mosi_s2_r <= mosi_s1_r;
        end
    end

    assign sck_rise_s = sck_s2_r & ~sck_d_r;

    // Frame FSM: CS deassertion is tested before SCK so it wins a tie.
    always_comb begin
        state_nx     = state_r;
        beat_nx      = beat_r;
        shift_nx     = shift_r;
        push_nx      = 1'b0;
        frame_err_nx = 1'b0;
        case (state_r)
            IDLE: begin
                if (!cs_s2_r) begin
                    state_nx = RECV;
                    beat_nx  = '0;
                    shift_nx = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            RECV: begin
                if (cs_s2_r) begin
                    state_nx     = IDLE;
                    frame_err_nx = 1'b1;
                end else if (sck_rise_s) begin
                    shift_nx = (shift_r << P_DATA_WIDTH) | W'(mosi_s2_r);
                    if (beat_r == BEAT_W'(P_BEATS - 1)) begin
                        state_nx = HOLD;
                        beat_nx  = '0;
                        push_nx  = 1'b1;
                    end else begin
                        beat_nx = beat_r + BEAT_W'(1);
                    end
                end else begin
                    state_nx = RECV;
                end
            end
            HOLD: begin
                if (cs_s2_r) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = HOLD;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FSM state, assembly register and registered status pulses. The push
    // is registered so the FIFO writes the completed shift register value.
    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) begin
            state_r     <= IDLE;
            beat_r      <= '0;
            shift_r     <= '0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_nx;
            beat_r      <= beat_nx;
            shift_r     <= shift_nx;
            push_r      <= push_nx;
            frame_err_r <= frame_err_nx;
            busy_r      <= (state_nx != IDLE);
            overflow_r  <= push_r & fifo_full_s & ~pop_s;
        end
    end

    assign pop_s = ready & ~fifo_empty_s;

    spi_rx_fifo #(
        .P_WIDTH (W),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_100),
        .rst_n   (a_rst),
        .push    (push_r),
        .wr_data (shift_r),
        .pop     (pop_s),
        .rd_data (data),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign valid     = ~fifo_empty_s;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_spi_receiver.sv
// Self-checking bench for spi_receiver with 8 lanes, 2 beats per frame and
// a 2-deep output buffer. SCK period is 80 ns against a 10 ns system clock.
module tb_spi_receiver;

    logic        clk_100 = 1'b0;
    logic        a_rst   = 1'b0;
    logic        SCK     = 1'b0;
    logic        CS      = 1'b1;
    logic [7:0]  MOSI    = 8'h00;
    logic [15:0] data;
    logic        valid;
    logic        ready   = 1'b1;
    logic        busy;
    logic        frame_err;
    logic        overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] got_q [$];
    int          ferr_cnt = 0;
    int          ovf_cnt  = 0;

    typedef struct {
        int          nbeats;
        logic [31:0] bytes;     // beat i is bytes[31-8*i -: 8]
        int          exp_words;
        logic [15:0] exp_data;
        int          exp_ferr;
    } vec_t;

    vec_t vecs [7];

    spi_receiver #(
        .P_DATA_WIDTH (8),
        .P_BEATS      (2),
        .P_FIFO_DEPTH (2)
    ) dut (
        .clk_100   (clk_100),
        .a_rst     (a_rst),
        .SCK       (SCK),
        .CS        (CS),
        .MOSI      (MOSI),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk_100 = ~clk_100;

    // Observe accepted words and status pulses away from the active edge.
    always @(negedge clk_100) begin
        if (a_rst) begin
            if (valid && ready) got_q.push_back(data);
            if (frame_err) ferr_cnt++;
            if (overflow) ovf_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_100);
        #2;
    endtask

    task automatic clear_mon();
        got_q.delete();
        ferr_cnt = 0;
        ovf_cnt  = 0;
    endtask

    task automatic send_frame(input int nb, input logic [31:0] bytes);
        wait_cyc(1);
        CS = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < nb; i++) begin
            MOSI = bytes[31-8*i -: 8];
            wait_cyc(4);
            SCK = 1'b1;
            wait_cyc(4);
            SCK = 1'b0;
        end
        wait_cyc(4);
        CS = 1'b1;
        wait_cyc(8);
    endtask

    initial begin
        int lat;

        vecs[0] = '{2, 32'hA53C_0000, 1, 16'hA53C, 0};
        vecs[1] = '{1, 32'hFF00_0000, 0, 16'h0000, 1};
        vecs[2] = '{2, 32'h1122_0000, 1, 16'h1122, 0};
        vecs[3] = '{4, 32'h1122_3344, 1, 16'h1122, 0};
        vecs[4] = '{2, 32'h00FF_0000, 1, 16'h00FF, 0};
        vecs[5] = '{0, 32'h0000_0000, 0, 16'h0000, 1};
        vecs[6] = '{2, 32'hFF00_0000, 1, 16'hFF00, 0};

        // Reset state
        #3;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {16'd0, data}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        wait_cyc(2);
        a_rst = 1'b1;
        wait_cyc(4);

        // Table-driven frames with ready held high
        for (int v = 0; v < 7; v++) begin
            clear_mon();
            send_frame(vecs[v].nbeats, vecs[v].bytes);
            check($sformatf("v%0d_words", v), got_q.size(), vecs[v].exp_words);
            if (got_q.size() > 0 && vecs[v].exp_words > 0)
                check($sformatf("v%0d_data", v), {16'd0, got_q[0]}, {16'd0, vecs[v].exp_data});
            check($sformatf("v%0d_frame_err", v), ferr_cnt, vecs[v].exp_ferr);
            check($sformatf("v%0d_overflow", v), ovf_cnt, 0);
            check($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_valid", v), {31'd0, valid}, 32'd0);
        end

        // Latency from the final SCK rise to valid with an empty buffer
        clear_mon();
        ready = 1'b0;
        CS = 1'b0;
        wait_cyc(4);
        MOSI = 8'h5A;
        wait_cyc(4);
        SCK = 1'b1;
        wait_cyc(4);
        SCK = 1'b0;
        MOSI = 8'hC3;
        wait_cyc(4);
        SCK = 1'b1;
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_100);
            #1;
            lat++;
            if (valid) break;
        end
        check("latency_cycles", lat, 4);
        check("latency_data", {16'd0, data}, 32'h5AC3);
        wait_cyc(3);
        SCK = 1'b0;
        wait_cyc(4);
        CS = 1'b1;
        wait_cyc(6);
        ready = 1'b1;
        wait_cyc(3);
        check("latency_words", got_q.size(), 1);
        if (got_q.size() > 0) check("latency_pop", {16'd0, got_q[0]}, 32'h5AC3);

        // Backpressure: third frame overflows a 2-deep buffer
        clear_mon();
        ready = 1'b0;
        send_frame(2, 32'h0102_0000);
        send_frame(2, 32'h0304_0000);
        check("bp_no_ovf_yet", ovf_cnt, 0);
        send_frame(2, 32'h0506_0000);
        check("bp_ovf_once", ovf_cnt, 1);
        check("bp_valid_held", {31'd0, valid}, 32'd1);
        check("bp_data_held", {16'd0, data}, 32'h0102);
        ready = 1'b1;
        wait_cyc(4);
        check("bp_words", got_q.size(), 2);
        if (got_q.size() > 1) begin
            check("bp_word0", {16'd0, got_q[0]}, 32'h0102);
            check("bp_word1", {16'd0, got_q[1]}, 32'h0304);
        end
        check("bp_drained", {31'd0, valid}, 32'd0);

        // Reset mid-frame with one word buffered
        clear_mon();
        ready = 1'b0;
        send_frame(2, 32'h1234_0000);
        check("rm_buffered", {31'd0, valid}, 32'd1);
        CS = 1'b0;
        wait_cyc(4);
        MOSI = 8'h77;
        wait_cyc(4);
        SCK = 1'b1;
        wait_cyc(4);
        SCK = 1'b0;
        wait_cyc(2);
        check("rm_busy_before", {31'd0, busy}, 32'd1);
        a_rst = 1'b0;
        #1;
        check("rm_valid", {31'd0, valid}, 32'd0);
        check("rm_busy", {31'd0, busy}, 32'd0);
        check("rm_data", {16'd0, data}, 32'd0);
        CS = 1'b1;
        wait_cyc(3);
        a_rst = 1'b1;
        wait_cyc(6);
        check("rm_no_frame_err", ferr_cnt, 0);
        check("rm_idle_after", {31'd0, busy}, 32'd0);
        ready = 1'b1;
        send_frame(2, 32'hBEEF_0000);
        check("rm_words", got_q.size(), 1);
        if (got_q.size() > 0) check("rm_beef", {16'd0, got_q[0]}, 32'hBEEF);
        check("rm_frame_err_end", ferr_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spi_receiver.md
SPI_RECEIVER -- requirements
Module: spi_receiver

Interface
REQ-001 SHALL take parameter P_DATA_WIDTH, default config_pkg::P_DATA_WIDTH, meaning MOSI lanes per SCK beat.
REQ-002 SHALL take parameter P_BEATS, default config_pkg::P_BEATS (4), meaning SCK beats per frame.
REQ-003 SHALL take parameter P_FIFO_DEPTH, default 2, meaning output word buffer depth.
REQ-004 SHALL have port clk_100  input  1  system clock, one clock domain.
REQ-005 SHALL have port a_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port SCK  input  1  serial clock, asynchronous to clk_100.
REQ-007 SHALL have port CS  input  1  chip select, active-low, asynchronous.
REQ-008 SHALL have port MOSI  input  P_DATA_WIDTH  parallel serial data lanes.
REQ-009 SHALL have port data  output  P_BEATS*P_DATA_WIDTH  received word.
REQ-010 SHALL have port valid  output  1  data holds an unread word.
REQ-011 SHALL have port ready  input  1  consumer accepts data.
REQ-012 SHALL have port busy  output  1  frame in progress (state RECV or HOLD).
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse when a frame is aborted.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-015 SHALL pass SCK, CS and MOSI each through 2-flop synchronizers, so all three stay mutually aligned.
REQ-016 SHALL detect an SCK rising edge as synced SCK=1 with the previous synced SCK=0.
REQ-017 SHALL support SCK high and low phases of at least 3 clk_100 cycles each; faster SCK is out of scope.
REQ-018 SHALL implement FSM states IDLE, RECV and HOLD.
REQ-019 In IDLE, synced CS=0 SHALL move the FSM to RECV, clearing the beat counter and the shift register.
REQ-020 In RECV, each SCK rise SHALL shift synced MOSI into the shift register.
  - First beat lands in the MSB lanes.
  - Beat counter increments.
REQ-021 On the P_BEATS-th rise, the FSM SHALL push the assembled word to the FIFO and move to HOLD.
REQ-022 In HOLD, SCK edges SHALL be ignored; synced CS=1 SHALL move the FSM to IDLE.
REQ-023 In RECV, synced CS=1 before P_BEATS beats SHALL discard the partial word, pulse frame_err for one cycle and move to IDLE.
REQ-024 An SCK rise in the same cycle as CS deassertion SHALL be ignored; CS has priority.
REQ-025 valid SHALL be 1 whenever the FIFO is non-empty; data SHALL equal the FIFO head.
REQ-026 A word SHALL pop when valid&&ready; data and valid SHALL be stable while valid&&!ready.
REQ-027 A push to a full FIFO SHALL drop the new word and pulse overflow; a simultaneous pop SHALL be processed first, so no drop occurs.
REQ-028 Latency SHALL be 4 clk_100 cycles from the final SCK rise at the pin to valid=1 when the FIFO is empty.
REQ-029 FIFO pointers SHALL wrap modulo P_FIFO_DEPTH; the count SHALL never exceed P_FIFO_DEPTH.

Reset
REQ-030 Asserting a_rst low SHALL immediately put the FSM in IDLE and set valid=0, busy=0, frame_err=0, overflow=0, data=0, FIFO empty and synchronizers to CS=1, SCK=0.
REQ-031 Reset mid-frame SHALL discard partial and buffered words without pulsing frame_err.
REQ-032 After reset release, a frame SHALL start only on a fresh synced CS=0 observed in IDLE.

Structure
REQ-033 config_pkg SHALL hold P_DATA_WIDTH, P_BEATS and typedef enum spi_rx_state_t {IDLE, RECV, HOLD}.
REQ-034 The FIFO SHALL be a sub-module named spi_rx_fifo with push/pop/full/empty ports.
REQ-035 The FSM, synchronizers and shift register SHALL reside in spi_receiver.

Verification (P_DATA_WIDTH=8, P_BEATS=2, P_FIFO_DEPTH=2, SCK period 80 ns)
REQ-036 Single frame: CS low, MOSI 0xA5 then 0x3C, ready=1 -> one valid pulse with data=0xA53C, busy low after CS high.
REQ-037 Backpressure: 3 frames 0x0102, 0x0304, 0x0506 with ready=0 -> overflow pulses once on the third; then ready=1 yields 0x0102, 0x0304.
REQ-038 Abort: CS high after 1 beat (0xFF) -> frame_err pulses once, valid stays 0; the next full frame 0x1122 is received intact.
REQ-039 Extra edges: 4 SCK rises in one frame (0x11, 0x22, 0x33, 0x44) -> only 0x1122 is delivered, no error.
REQ-040 Reset: a_rst low mid-frame and with 1 word buffered -> valid=0 immediately, no frame_err; a subsequent frame 0xBEEF is received correctly.
